// File: rtl/multi_byte_add_seq.sv
// multi_byte_add_seq
//   Streaming carry-chain sequencer in front of an 8-bit combinational adder
//   core. Operand byte pairs arrive LSB first over valid/ready. A registered
//   operand stage drives the core. The core result is captured into a
//   registered output stage. The carry is chained between bytes, so one 8-bit
//   core can perform multi-byte add and subtract.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operand handshake
//   in_a, in_b                operand bytes
//   in_sub                    subtract (first byte of a packet only)
//   in_last                   most-significant byte of packet
//   add_a/add_b/add_cin       drive the adder core
//   add_sum/add_cout          returned from the adder core
//   out_valid/out_ready       result handshake
//   out_sum                   result byte
//   out_last                  final byte of packet
//   out_carry                 carry-out of the final byte (sub: 1 = no borrow)
//   out_ovf                   signed overflow of the final byte
//   out_err                   packet was truncated at MAX_BYTES
module multi_byte_add_seq #(
  parameter int MAX_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_sub,
  input  logic       in_last,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_last,
  output logic       out_carry,
  output logic       out_ovf,
  output logic       out_err
);
  localparam int CW = $clog2(MAX_BYTES + 1);

  logic          op_valid, op_sub, op_first, op_last, op_err;
  logic [7:0]    op_a, op_b;
  logic          carry_q, first_q, sub_q;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          in_fire, mv, out_fire, trunc, eff_last;

  assign mv       = op_valid & (!out_valid | out_ready);
  assign in_ready = !op_valid | !out_valid | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // A packet reaching MAX_BYTES without in_last is forcibly closed here.
  // The next byte then starts a new packet.
  assign cnt_nxt  = cnt + CW'(1);
  assign trunc    = (cnt_nxt == CW'(MAX_BYTES)) & !in_last;
  assign eff_last = in_last | trunc;

  // Subtraction is computed as A + ~B + 1. The +1 enters on the first byte only.
  assign add_a   = op_a;
  assign add_b   = op_sub ? ~op_b : op_b;
  assign add_cin = op_first ? op_sub : carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_sub    <= 1'b0;
      op_first  <= 1'b0;
      op_last   <= 1'b0;
      op_err    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
      carry_q   <= 1'b0;
      first_q   <= 1'b1;
      sub_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      if (in_fire) begin
        op_a     <= in_a;
        op_b     <= in_b;
        op_first <= first_q;
        op_sub   <= first_q ? in_sub : sub_q;
        op_last  <= eff_last;
        op_err   <= trunc;
        if (first_q) sub_q <= in_sub;
        if (eff_last) begin
          first_q <= 1'b1;
          cnt     <= '0;
        end else begin
          first_q <= 1'b0;
          cnt     <= cnt_nxt;
        end
      end

      if (in_fire)  op_valid <= 1'b1;
      else if (mv)  op_valid <= 1'b0;

      if (mv) begin
        out_sum   <= add_sum;
        out_last  <= op_last;
        out_err   <= op_err;
        out_carry <= op_last & add_cout;
        out_ovf   <= op_last & (add_a[7] == add_b[7]) & (add_sum[7] != add_a[7]);
        // The carry is dropped at a packet boundary. The next packet then starts clean.
        carry_q   <= op_last ? 1'b0 : add_cout;
      end

      if (mv)            out_valid <= 1'b1;
      else if (out_fire) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multi_byte_add_seq.sv
module tb_multi_byte_add_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_sub, in_last;
  logic [7:0] in_a, in_b;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       out_valid, out_ready, out_last, out_carry, out_ovf, out_err;
  logic [7:0] out_sum;

  int total = 0;
  int bad   = 0;
  logic [11:0] q[$];

  always #5 clk = ~clk;

  // Stand-in for the 8-bit adder core.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  multi_byte_add_seq #(.MAX_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_last(out_last), .out_carry(out_carry), .out_ovf(out_ovf), .out_err(out_err)
  );

  // Record each accepted result byte as {sum, last, carry, ovf, err}.
  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      q.push_back({out_sum, out_last, out_carry, out_ovf, out_err});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic last);
    logic rdy;
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_last = last;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] s, input logic l,
                            input logic c, input logic o, input logic e);
    int n;
    n = 0;
    while (q.size() == 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() == 0) chk({tag, "_timeout"}, 0, 1);
    else chk(tag, {20'h0, q.pop_front()}, {20'h0, s, l, c, o, e});
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_last = 1'b0;
    cycles(2);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_regs", {out_sum, out_last, out_carry, out_ovf, out_err}, 0);

    // Single-byte add with signed overflow; also checks the two-cycle latency.
    send(8'h7F, 8'h01, 1'b0, 1'b1);
    chk("t1_out_valid_early", out_valid, 0);
    chk("t1_add_a", add_a, 8'h7F);
    chk("t1_cin", add_cin, 0);
    cycles(1);
    chk("t1_out_valid_lat", out_valid, 1);
    expect_out("t1_res", 8'h80, 1, 0, 1, 0);

    // Two-byte add where the carry propagates into byte 2.
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    send(8'h01, 8'h00, 1'b0, 1'b1);
    chk("t2_cin_b2", add_cin, 1);
    expect_out("t2_b1", 8'h00, 0, 0, 0, 0);
    expect_out("t2_b2", 8'h02, 1, 0, 0, 0);

    // 0x0000 - 0x0001. in_sub on byte 2 must be ignored.
    send(8'h00, 8'h01, 1'b1, 1'b0);
    chk("t3_cin_b1", add_cin, 1);
    chk("t3_add_b", add_b, 8'hFE);
    send(8'h00, 8'h00, 1'b0, 1'b1);
    chk("t3_add_b2", add_b, 8'hFF);
    expect_out("t3_b1", 8'hFF, 0, 0, 0, 0);
    expect_out("t3_b2", 8'hFF, 1, 0, 0, 0);

    // Backpressure: only two bytes can be buffered.
    out_ready = 1'b0;
    send(8'h10, 8'h01, 1'b0, 1'b0);
    send(8'h20, 8'h02, 1'b0, 1'b0);
    chk("t4_rdy_low", in_ready, 0);
    chk("t4_hold_a", out_sum, 8'h11);
    cycles(1);
    chk("t4_hold_b", out_sum, 8'h11);
    chk("t4_rdy_low2", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("t4_rdy_comb", in_ready, 1);
    send(8'h30, 8'h03, 1'b0, 1'b0);
    send(8'h40, 8'h04, 1'b0, 1'b1);
    expect_out("t4_b1", 8'h11, 0, 0, 0, 0);
    expect_out("t4_b2", 8'h22, 0, 0, 0, 0);
    expect_out("t4_b3", 8'h33, 0, 0, 0, 0);
    expect_out("t4_b4", 8'h44, 1, 0, 0, 0);
    cycles(4);
    chk("t4_no_dup", q.size(), 0);

    // Truncation at 4 bytes. The 5th byte opens a new packet.
    for (int i = 0; i < 4; i++) send(8'h01, 8'h01, 1'b0, 1'b0);
    send(8'h01, 8'h01, 1'b0, 1'b0);
    chk("t5_cin_new", add_cin, 0);
    send(8'h00, 8'h00, 1'b0, 1'b1);
    expect_out("t5_b1", 8'h02, 0, 0, 0, 0);
    expect_out("t5_b2", 8'h02, 0, 0, 0, 0);
    expect_out("t5_b3", 8'h02, 0, 0, 0, 0);
    expect_out("t5_b4", 8'h02, 1, 0, 0, 1);
    expect_out("t5_b5", 8'h02, 0, 0, 0, 0);
    expect_out("t5_b6", 8'h00, 1, 0, 0, 0);

    // Reset mid-packet with carry_q set. The carry must not leak into the next packet.
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    send(8'hFF, 8'h00, 1'b0, 1'b0);
    expect_out("t6_b1", 8'h00, 0, 0, 0, 0);
    expect_out("t6_b2", 8'h00, 0, 0, 0, 0);
    cycles(1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("t6_rst_ovld", out_valid, 0);
    chk("t6_rst_rdy", in_ready, 1);
    send(8'h00, 8'h00, 1'b0, 1'b1);
    chk("t6_cin", add_cin, 0);
    expect_out("t6_res", 8'h00, 1, 0, 0, 0);

    // A held result byte is discarded by reset.
    out_ready = 1'b0;
    send(8'h05, 8'h05, 1'b0, 1'b1);
    cycles(2);
    chk("t7_held", out_valid, 1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    out_ready = 1'b1;
    cycles(3);
    chk("t7_discard", out_valid, 0);
    chk("t7_q_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
